br_flow_mux_select_reg: RTL and testbench

Flow-controlled N:1 multiplexer with a selectable arbitration policy and a registered pop stage. It generalises the combinational fixed-priority flow mux: priority can be fixed or round-robin, and the pop interface is driven from flops, so pop_valid and pop_data are stable under backpressure. The pop interface also reports which flow the data came from. It sits between independent ready-valid producers and a single consumer that needs a timing-clean, stable output.

---
 rtl/br_flow_mux_pkg.sv | 14 +
 rtl/br_flow_mux_select_reg_if.sv | 27 ++
 rtl/br_flow_mux_arb_sel.sv | 42 ++++
 rtl/br_flow_mux_select_reg.sv | 113 +++++++++++
 tb/tb_br_flow_mux_select_reg.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/br_flow_mux_pkg.sv
// Shared types and helpers for the flow mux with registered pop stage.
// Arbitration policy enum and flow-id width derivation.
package br_flow_mux_pkg;

  typedef enum logic {
    ArbFixed      = 1'b0,
    ArbRoundRobin = 1'b1
  } arb_mode_e;

  function automatic int flow_id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/br_flow_mux_select_reg_if.sv
// Push/pop handshake bundle for the flow mux.
// master = producers/consumer side, slave = the mux.
interface br_flow_mux_select_reg_if #(
  parameter int NumFlows    = 2,
  parameter int Width       = 1,
  parameter int FlowIdWidth = 1
) ();

  logic [NumFlows-1:0]            push_valid;
  logic [NumFlows-1:0]            push_ready;
  logic [NumFlows-1:0][Width-1:0] push_data;
  logic                           pop_valid;
  logic                           pop_ready;
  logic [Width-1:0]               pop_data;
  logic [FlowIdWidth-1:0]         pop_flow_id;

  modport master (
    output push_valid, push_data, pop_ready,
    input  push_ready, pop_valid, pop_data, pop_flow_id
  );

  modport slave (
    input  push_valid, push_data, pop_ready,
    output push_ready, pop_valid, pop_data, pop_flow_id
  );

endinterface

// File: rtl/br_flow_mux_arb_sel.sv
// Combinational grant select: fixed priority or round-robin from i_ptr.
// Fixed mode is round-robin with the search start pinned to flow 0.
module br_flow_mux_arb_sel
  import br_flow_mux_pkg::*;
#(
  parameter int NumFlows    = 2,
  parameter int ArbMode     = 0,
  parameter int FlowIdWidth = 1
) (
  input  logic [NumFlows-1:0]    i_valid,
  input  logic [FlowIdWidth-1:0] i_ptr,
  input  logic                   i_en,
  output logic [NumFlows-1:0]    o_grant,
  output logic [FlowIdWidth-1:0] o_grant_id
);

  localparam int IW = FlowIdWidth + 1;

  logic [FlowIdWidth-1:0] w_start;
  logic [IW-1:0]          w_idx;
  logic                   w_found;

  assign w_start = (ArbMode == int'(ArbRoundRobin)) ? i_ptr : '0;

  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int k = 0; k < NumFlows; k++) begin
      w_idx = {1'b0, w_start} + IW'(k);
      if (w_idx >= IW'(NumFlows)) w_idx = w_idx - IW'(NumFlows);
      if (!w_found && i_valid[w_idx[FlowIdWidth-1:0]]) begin
        w_found                         = 1'b1;
        o_grant[w_idx[FlowIdWidth-1:0]] = 1'b1;
        o_grant_id                      = w_idx[FlowIdWidth-1:0];
      end
    end
    if (!i_en) o_grant = '0;
  end

endmodule

// File: rtl/br_flow_mux_select_reg.sv
// N:1 flow mux with selectable arbitration and a single registered pop slot.
// Pop outputs come straight from flops and hold under backpressure.
module br_flow_mux_select_reg
  import br_flow_mux_pkg::*;
#(
  parameter int NumFlows                       = 2,
  parameter int Width                          = 1,
  parameter int ArbMode                        = 0,
  parameter int FlowIdWidth                    = flow_id_width(NumFlows),
  parameter int EnableAssertPushValidStability = 1,
  parameter int EnableAssertFinalNotValid      = 1
) (
  input logic                     clk,
  input logic                     rst,
  br_flow_mux_select_reg_if.slave io_flow
);

  logic                   r_pop_valid;
  logic [Width-1:0]       r_pop_data;
  logic [FlowIdWidth-1:0] r_pop_id;
  logic [FlowIdWidth-1:0] r_ptr;

  logic                   w_can_accept;
  logic [NumFlows-1:0]    w_grant;
  logic [FlowIdWidth-1:0] w_grant_id;
  logic                   w_push;

  assign w_can_accept = ~r_pop_valid | io_flow.pop_ready;
  assign w_push       = |w_grant;

  br_flow_mux_arb_sel #(
    .NumFlows    (NumFlows),
    .ArbMode     (ArbMode),
    .FlowIdWidth (FlowIdWidth)
  ) u_arb (
    .i_valid    (io_flow.push_valid),
    .i_ptr      (r_ptr),
    .i_en       (w_can_accept & ~rst),
    .o_grant    (w_grant),
    .o_grant_id (w_grant_id)
  );

  assign io_flow.push_ready  = w_grant;
  assign io_flow.pop_valid   = r_pop_valid;
  assign io_flow.pop_data    = r_pop_data;
  assign io_flow.pop_flow_id = r_pop_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pop_valid <= 1'b0;
      r_pop_data  <= '0;
      r_pop_id    <= '0;
    end else if (w_can_accept) begin
      r_pop_valid <= w_push;
      if (w_push) begin
        r_pop_data <= io_flow.push_data[w_grant_id];
        r_pop_id   <= w_grant_id;
      end
    end
  end

  // Pointer only moves on an accepted push; stays 0 in fixed mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (ArbMode == int'(ArbRoundRobin) && w_push) begin
      r_ptr <= (w_grant_id == FlowIdWidth'(NumFlows - 1)) ?
               '0 : w_grant_id + 1'b1;
    end
  end

`ifndef SYNTHESIS
  logic [NumFlows-1:0]    r_chk_pend;
  logic                   r_chk_bp;
  logic [Width-1:0]       r_chk_data;
  logic [FlowIdWidth-1:0] r_chk_id;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_chk_pend <= '0;
      r_chk_bp   <= 1'b0;
    end else begin
      r_chk_pend <= io_flow.push_valid & ~io_flow.push_ready;
      r_chk_bp   <= r_pop_valid & ~io_flow.pop_ready;
    end
    r_chk_data <= r_pop_data;
    r_chk_id   <= r_pop_id;
    if (!rst) begin
      assert ($onehot0(w_grant));
      if (EnableAssertPushValidStability != 0)
        assert ((r_chk_pend & ~io_flow.push_valid) == '0);
      if (r_chk_bp)
        assert (r_pop_valid && r_pop_data == r_chk_data &&
                r_pop_id == r_chk_id);
      if (r_pop_valid)
        assert (!$isunknown({r_pop_data, r_pop_id}));
    end
  end

  for (genvar gi = 0; gi < NumFlows; gi++) begin : g_cov
    cover property (@(posedge clk) !rst && w_grant[gi]);
  end

  cover property (@(posedge clk)
    !rst && r_chk_bp && r_pop_valid && !io_flow.pop_ready);

  final begin
    if (EnableAssertFinalNotValid != 0)
      assert (io_flow.push_valid == '0 && !r_pop_valid);
  end
`endif

endmodule

// File: tb/tb_br_flow_mux_select_reg.sv
// Directed bench: fixed 4-flow and round-robin 3-flow instances.
// Inputs change just after negedge; outputs sampled there too.
module tb_br_flow_mux_select_reg;
  import br_flow_mux_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cnt;

  always #5 clk = ~clk;

  br_flow_mux_select_reg_if #(
    .NumFlows(4), .Width(8), .FlowIdWidth(2)
  ) f_if ();

  br_flow_mux_select_reg_if #(
    .NumFlows(3), .Width(8), .FlowIdWidth(2)
  ) r_if ();

  br_flow_mux_select_reg #(
    .NumFlows(4), .Width(8), .ArbMode(0)
  ) u_fx (
    .clk     (clk),
    .rst     (rst),
    .io_flow (f_if.slave)
  );

  br_flow_mux_select_reg #(
    .NumFlows(3), .Width(8), .ArbMode(1)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .io_flow (r_if.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst             = 1'b1;
    f_if.push_valid = '0;
    f_if.push_data  = '0;
    f_if.pop_ready  = 1'b0;
    r_if.push_valid = '0;
    r_if.push_data  = '0;
    r_if.pop_ready  = 1'b0;

    // reset state, push_ready forced low during reset
    nxt;
    f_if.push_valid = 4'hF;
    #1 chk("rst_f_ready", f_if.push_ready, 0);
    f_if.push_valid = '0;
    nxt;
    chk("rst_f_pv", f_if.pop_valid, 0);
    chk("rst_f_pd", f_if.pop_data, 0);
    chk("rst_f_id", f_if.pop_flow_id, 0);
    chk("rst_r_pv", r_if.pop_valid, 0);
    chk("rst_r_pd", r_if.pop_data, 0);
    rst = 1'b0;

    // 1: fixed priority, flows 1 and 3 valid
    f_if.push_data  = {8'h33, 8'h22, 8'h11, 8'h00};
    f_if.push_valid = 4'b1010;
    f_if.pop_ready  = 1'b1;
    #1 chk("t1_ready0", f_if.push_ready, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      nxt;
      chk("t1_pv", f_if.pop_valid, 1);
      chk("t1_id", f_if.pop_flow_id, 1);
      chk("t1_pd", f_if.pop_data, 8'h11);
      chk("t1_ready", f_if.push_ready, 4'b0010);
    end
    f_if.push_valid = 4'b1000;
    #1 chk("t1_ready3", f_if.push_ready, 4'b1000);
    nxt;
    chk("t1_id3", f_if.pop_flow_id, 3);
    chk("t1_pd3", f_if.pop_data, 8'h33);
    f_if.push_valid = '0;
    nxt;
    chk("t1_drain", f_if.pop_valid, 0);

    // 2: round-robin, all three flows valid
    r_if.push_data  = {8'd2, 8'd1, 8'd0};
    r_if.push_valid = 3'b111;
    r_if.pop_ready  = 1'b1;
    #1 chk("t2_ready0", r_if.push_ready, 3'b001);
    for (int k = 0; k < 6; k++) begin
      nxt;
      chk("t2_id", r_if.pop_flow_id, k % 3);
      chk("t2_pd", r_if.pop_data, k % 3);
      chk("t2_ready", r_if.push_ready, 1 << ((k + 1) % 3));
    end
    rst             = 1'b1;
    r_if.push_valid = '0;
    r_if.pop_ready  = 1'b0;
    nxt;
    rst = 1'b0;

    // 3: backpressure holds slot, ptr frozen
    r_if.push_data  = {8'hA5, 8'h00, 8'h00};
    r_if.push_valid = 3'b100;
    r_if.pop_ready  = 1'b1;
    #1 chk("t3_ready2", r_if.push_ready, 3'b100);
    nxt;
    chk("t3_pd", r_if.pop_data, 8'hA5);
    chk("t3_id", r_if.pop_flow_id, 2);
    r_if.pop_ready  = 1'b0;
    r_if.push_data  = {8'h00, 8'h00, 8'h3C};
    r_if.push_valid = 3'b001;
    #1 chk("t3_ready_bp", r_if.push_ready, 0);
    for (int k = 0; k < 5; k++) begin
      nxt;
      chk("t3_hold_pv", r_if.pop_valid, 1);
      chk("t3_hold_pd", r_if.pop_data, 8'hA5);
      chk("t3_hold_id", r_if.pop_flow_id, 2);
      chk("t3_hold_rdy", r_if.push_ready, 0);
    end
    r_if.pop_ready = 1'b1;
    #1 chk("t3_ready0", r_if.push_ready, 3'b001);
    nxt;
    chk("t3_pd0", r_if.pop_data, 8'h3C);
    chk("t3_id0", r_if.pop_flow_id, 0);
    r_if.push_valid = '0;
    nxt;
    chk("t3_drain", r_if.pop_valid, 0);

    // 6: sparse request with ptr=1
    r_if.push_data  = {8'h00, 8'h77, 8'h5A};
    r_if.push_valid = 3'b001;
    #1 chk("t6_ready0", r_if.push_ready, 3'b001);
    nxt;
    chk("t6_id0", r_if.pop_flow_id, 0);
    chk("t6_pd0", r_if.pop_data, 8'h5A);
    r_if.push_valid = 3'b011;
    #1 chk("t6_ptr1", r_if.push_ready, 3'b010);
    nxt;
    chk("t6_id1", r_if.pop_flow_id, 1);
    chk("t6_pd1", r_if.pop_data, 8'h77);
    r_if.push_valid = 3'b001;
    #1 chk("t6_ready_wrap", r_if.push_ready, 3'b001);
    nxt;
    chk("t6_id_wrap", r_if.pop_flow_id, 0);
    r_if.push_valid = '0;
    nxt;
    chk("t6_drain", r_if.pop_valid, 0);

    // 4: back-to-back, ptr=1 at start
    r_if.push_data  = {8'd2, 8'd1, 8'd0};
    r_if.push_valid = 3'b111;
    #1 chk("t4_ready1", r_if.push_ready, 3'b010);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      nxt;
      chk("t4_pv", r_if.pop_valid, 1);
      chk("t4_id", r_if.pop_flow_id, (1 + k) % 3);
      if (r_if.pop_valid && r_if.pop_ready) cnt++;
    end
    chk("t4_count", cnt, 8);

    // 5: reset under backpressure with ptr=1
    nxt;
    chk("t5_id0", r_if.pop_flow_id, 0);
    r_if.pop_ready = 1'b0;
    nxt;
    chk("t5_hold_pv", r_if.pop_valid, 1);
    chk("t5_hold_id", r_if.pop_flow_id, 0);
    rst = 1'b1;
    #1 chk("t5_rst_ready", r_if.push_ready, 0);
    nxt;
    rst = 1'b0;
    chk("t5_pv", r_if.pop_valid, 0);
    chk("t5_pd", r_if.pop_data, 0);
    chk("t5_id", r_if.pop_flow_id, 0);
    r_if.pop_ready = 1'b1;
    #1 chk("t5_ready_ptr0", r_if.push_ready, 3'b001);
    nxt;
    chk("t5_first_id", r_if.pop_flow_id, 0);

    rst             = 1'b1;
    r_if.push_valid = '0;
    f_if.push_valid = '0;
    nxt;
    rst = 1'b0;
    nxt;
    chk("end_r_pv", r_if.pop_valid, 0);
    chk("end_f_pv", f_if.pop_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
